sseg_scan_decoder: RTL and testbench
====================================

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 SHALL have parameter N_STABLE, default 4: consecutive cycles a scan value must hold before capture (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_W, default 20: width of the stale-display timer.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port an, input, 8: anode enables, active-low, bit i = digit i.
REQ-006 SHALL have port sseg, input, 8: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
REQ-007 SHALL have port seg_pat, output, 56: captured patterns, active-high {g..a}; digit i at [7i+6:7i].
REQ-008 SHALL have port dp, output, 8: captured decimal points, active-high.
REQ-009 SHALL have port hex, output, 32: decoded nibbles; digit i at [4i+3:4i].
REQ-010 SHALL have port hex_ok, output, 8: digit i pattern matched a hex glyph.
REQ-011 SHALL have port digit_vld, output, 8: digit i captured since reset or last stale event.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse on scan frame completion.
REQ-013 SHALL have port an_err, output, 1: one-cycle pulse on stable multi-anode value.
REQ-014 SHALL have port stale, output, 1: level; no capture for 2^TIMEOUT_W-1 cycles.

Function
REQ-015 SHALL register {an,sseg} once (in_q); all detection uses in_q.
REQ-016 SHALL implement FSM WAIT/COUNT/HOLD with a stability counter.
REQ-017 WAIT: in_q with an != 8'hFF -> COUNT, cnt=1; an == 8'hFF stays WAIT.
REQ-018 COUNT: cnt increments each unchanged cycle; on reaching N_STABLE -> HOLD with capture or an_err.
REQ-019 Any change of in_q in COUNT or HOLD SHALL restart: -> COUNT cnt=1 (or WAIT if an == 8'hFF).
REQ-020 HOLD: no further captures until in_q changes; a value is captured at most once per stable window.
REQ-021 Capture (exactly one an bit low, index d): seg_pat[d] <= ~sseg[6:0], dp[d] <= ~sseg[7], digit_vld[d] <= 1, hex/hex_ok[d] updated.
REQ-022 Latency: value first in in_q after edge t and held SHALL update outputs after edge t+N_STABLE-1; total input-to-output N_STABLE cycles.
REQ-023 Stable value with >1 anode low SHALL pulse an_err in the capture cycle, write nothing.
REQ-024 Hex table (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; no match -> nibble 0, hex_ok 0.
REQ-025 SHALL keep seen mask; capture on d with seen[d]=1 -> frame_done pulse same cycle as outputs update, seen <= onehot(d); else seen |= onehot(d).
REQ-026 Timer SHALL clear on capture, else increment, saturating at all-ones; at saturation stale=1, digit_vld and seen cleared, seg_pat/hex retained.
REQ-027 Capture in the saturation cycle SHALL win: timer cleared, stale=0, digit_vld[d] set.

Reset
REQ-028 rst SHALL force: FSM WAIT, cnt 0, in_q 16'hFFFF, seg_pat 0, dp 0, hex 0, hex_ok 0, digit_vld 0, seen 0, timer 0, frame_done 0, an_err 0, stale 0.
REQ-029 rst mid-COUNT SHALL abort the pending capture; held value needs a fresh N_STABLE cycles after release.

Configuration
REQ-030 Macro SSEG_DEC_HEX_EN defined: hex and hex_ok driven per REQ-024.
REQ-031 Macro SSEG_DEC_HEX_EN undefined: no decode logic; hex tied 0, hex_ok tied 0; ports unchanged; all else identical.

Verification (N_STABLE=4, TIMEOUT_W=8)
REQ-032 an=8'hFE, sseg=8'hC0 held 6 cycles -> after 4 cycles seg_pat[6:0]=7'h3F, hex[3:0]=0, hex_ok[0]=1, digit_vld=8'h01; single capture only.
REQ-033 an=8'hF7, sseg=8'h9C held -> seg_pat digit3=7'h63, hex_ok[3]=0, hex digit3=0, dp[3]=0.
REQ-034 an=8'hFD, sseg toggled every 3 cycles -> no capture, digit_vld unchanged, no an_err.
REQ-035 scan digits 0,1,2,3,0 (5 cycles each) -> frame_done single pulse on second digit-0 capture, digit_vld=8'h0F.
REQ-036 an=8'hFC held 5 cycles -> an_err one pulse, no output change; then hold an=8'hFF 255 cycles -> stale=1, digit_vld=0, seg_pat retained.
REQ-037 rst asserted in cycle 3 of a hold -> all outputs reset values; capture after 4 further cycles post-release.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Recovers per-digit segment patterns from a multiplexed 7-segment scan bus.
// Define SSEG_DEC_HEX_EN to add the glyph-to-hex decoder driving hex/hex_ok.
module sseg_scan_decoder #(
    parameter int N_STABLE  = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  sseg,
    output logic [55:0] seg_pat,
    output logic [7:0]  dp,
    output logic [31:0] hex,
    output logic [7:0]  hex_ok,
    output logic [7:0]  digit_vld,
    output logic        frame_done,
    output logic        an_err,
    output logic        stale
);
    typedef enum logic [1:0] {WAIT, COUNT, HOLD} state_t;

    localparam logic [7:0]           CNT_TOP   = 8'(N_STABLE);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

    state_t               state_reg, state_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic [15:0]          in_q_reg;
    logic [15:0]          in_next;
    logic                 changed;
    logic                 stable_hit;
    logic [7:0]           an_low;
    logic                 one_hot;
    logic                 cap;
    logic [7:0]           wr_en;
    logic [7:0]           seen_reg, seen_next;
    logic [TIMEOUT_W-1:0] timer_reg, timer_next;
    logic                 timeout;
    logic                 frame_done_reg;
    logic                 an_err_reg;
    logic                 stale_reg;

    // Change is judged on the value about to enter in_q, so the edge that loads
    // a new value also starts its count; this keeps capture N_STABLE edges out.
    assign in_next = {an, sseg};
    assign changed = (in_next != in_q_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q_reg  <= 16'hFFFF;
            state_reg <= WAIT;
            cnt_reg   <= '0;
        end else begin
            in_q_reg  <= in_next;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stable_hit = 1'b0;
        case (state_reg)
            WAIT: begin
                if (an != 8'hFF) begin
                    state_next = COUNT;
                    cnt_next   = 8'd1;
                end
            end
            COUNT, HOLD: begin
                if (changed) begin
                    state_next = (an == 8'hFF) ? WAIT : COUNT;
                    cnt_next   = (an == 8'hFF) ? 8'd0 : 8'd1;
                end else if (state_reg == COUNT) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_next == CNT_TOP) begin
                        state_next = HOLD;
                        stable_hit = 1'b1;
                    end
                end
            end
            default: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign an_low  = ~in_q_reg[15:8];
    assign one_hot = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
    assign cap     = stable_hit && one_hot;
    assign wr_en   = cap ? an_low : 8'h00;

    always_comb begin
        if (cap)
            timer_next = '0;
        else if (timer_reg == TIMER_MAX)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + TIMEOUT_W'(1);
    end

    assign timeout = !cap && (timer_next == TIMER_MAX);

    // A repeat visit to an already-seen digit closes the frame and opens the next.
    always_comb begin
        seen_next = seen_reg;
        if (cap)
            seen_next = ((seen_reg & wr_en) != 8'h00) ? wr_en : (seen_reg | wr_en);
        else if (timeout)
            seen_next = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg       <= '0;
            timer_reg      <= '0;
            frame_done_reg <= 1'b0;
            an_err_reg     <= 1'b0;
            stale_reg      <= 1'b0;
        end else begin
            seen_reg       <= seen_next;
            timer_reg      <= timer_next;
            frame_done_reg <= cap && ((seen_reg & wr_en) != 8'h00);
            an_err_reg     <= stable_hit && !one_hot;
            stale_reg      <= timeout;
        end
    end

    assign frame_done = frame_done_reg;
    assign an_err     = an_err_reg;
    assign stale      = stale_reg;

`ifdef SSEG_DEC_HEX_EN
    // Returns {match, nibble}; unrecognised patterns decode to 0 with no match.
    function automatic logic [4:0] glyph_to_hex(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0] dec;
    assign dec = glyph_to_hex(~in_q_reg[6:0]);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [6:0] pat_reg;
            logic       dp_reg;
            logic       vld_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pat_reg <= '0;
                    dp_reg  <= 1'b0;
                    vld_reg <= 1'b0;
                end else if (wr_en[gi]) begin
                    pat_reg <= ~in_q_reg[6:0];
                    dp_reg  <= ~in_q_reg[7];
                    vld_reg <= 1'b1;
                end else if (timeout) begin
                    vld_reg <= 1'b0;
                end
            end

            assign seg_pat[7*gi+6:7*gi] = pat_reg;
            assign dp[gi]               = dp_reg;
            assign digit_vld[gi]        = vld_reg;

`ifdef SSEG_DEC_HEX_EN
            logic [3:0] hex_reg;
            logic       ok_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hex_reg <= '0;
                    ok_reg  <= 1'b0;
                end else if (wr_en[gi]) begin
                    hex_reg <= dec[3:0];
                    ok_reg  <= dec[4];
                end
            end

            assign hex[4*gi+3:4*gi] = hex_reg;
            assign hex_ok[gi]       = ok_reg;
`else
            assign hex[4*gi+3:4*gi] = 4'h0;
            assign hex_ok[gi]       = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Randomised and directed bench for sseg_scan_decoder against a run-length reference model.
module tb_sseg_scan_decoder;
    localparam int NS   = 4;
    localparam int TW   = 8;
    localparam int TMAX = 255;
`ifdef SSEG_DEC_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [7:0]  sseg;
    logic [55:0] seg_pat;
    logic [7:0]  dp;
    logic [31:0] hex;
    logic [7:0]  hex_ok;
    logic [7:0]  digit_vld;
    logic        frame_done;
    logic        an_err;
    logic        stale;

    sseg_scan_decoder #(.N_STABLE(NS), .TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .sseg       (sseg),
        .seg_pat    (seg_pat),
        .dp         (dp),
        .hex        (hex),
        .hex_ok     (hex_ok),
        .digit_vld  (digit_vld),
        .frame_done (frame_done),
        .an_err     (an_err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: expected outputs after the next clock edge.
    logic [55:0] m_seg;
    logic [7:0]  m_dp, m_hex_ok, m_vld, m_seen;
    logic [31:0] m_hex;
    logic        m_frame, m_err, m_stale;
    logic [15:0] m_prev;
    int          m_run, m_idle;

    logic [114:0] obs, exp_v;
    assign obs   = {seg_pat, dp, hex, hex_ok, digit_vld, frame_done, an_err, stale};
    assign exp_v = {m_seg, m_dp, m_hex, m_hex_ok, m_vld, m_frame, m_err, m_stale};

    task automatic model_step();
        logic [15:0] cur;
        int          d;
        logic [3:0]  nib;
        logic        ok;
        if (rst) begin
            m_seg = '0; m_dp = '0; m_hex = '0; m_hex_ok = '0; m_vld = '0; m_seen = '0;
            m_frame = 1'b0; m_err = 1'b0; m_stale = 1'b0;
            m_prev = 16'hFFFF; m_run = 0; m_idle = 0;
        end else begin
            cur     = {an, sseg};
            m_run   = (cur == m_prev) ? m_run + 1 : 1;
            m_prev  = cur;
            m_frame = 1'b0;
            m_err   = 1'b0;
            d       = -1;
            if (an != 8'hFF && m_run == NS) begin
                if ($countones(~an) == 1) begin
                    for (int i = 0; i < 8; i++) if (!an[i]) d = i;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (d >= 0) begin
                m_seg[7*d +: 7] = ~sseg[6:0];
                m_dp[d]         = ~sseg[7];
                nib = 4'h0; ok = 1'b0;
                for (int g = 0; g < 16; g++) begin
                    if (glyph[g] == ~sseg[6:0]) begin nib = 4'(g); ok = 1'b1; end
                end
                if (HEX_EN) begin
                    m_hex[4*d +: 4] = nib;
                    m_hex_ok[d]     = ok;
                end
                if (m_seen[d]) begin m_frame = 1'b1; m_seen = 8'h01 << d; end
                else m_seen[d] = 1'b1;
                m_vld[d] = 1'b1;
                m_idle   = 0;
            end else begin
                if (m_idle < TMAX) m_idle++;
                if (m_idle == TMAX) begin m_vld = '0; m_seen = '0; end
            end
            m_stale = (m_idle == TMAX);
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] a, input logic [7:0] s);
        rst = r; an = a; sseg = s;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 8'hFF);
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", obs); end
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_single_capture();
        int pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 8'hFE, 8'hC0);
            pulses += int'(frame_done);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL capture_model k=%0d got=%h exp=%h", k, obs, exp_v); end
            n_tests++;
            if (digit_vld !== ((k >= NS) ? 8'h01 : 8'h00)) begin
                n_fail++; $display("FAIL capture_latency k=%0d got=%h exp=%h", k, digit_vld, (k >= NS) ? 8'h01 : 8'h00);
            end
        end
        n_tests++;
        if (seg_pat[6:0] !== 7'h3F || hex[3:0] !== 4'h0 || hex_ok[0] !== HEX_EN || pulses != 0) begin
            n_fail++; $display("FAIL capture_digit0 got=%h/%h/%b/%0d exp=3f/0/%b/0", seg_pat[6:0], hex[3:0], hex_ok[0], pulses, HEX_EN);
        end
    endtask

    task automatic test_unknown_glyph();
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, 8'hF7, 8'h9C);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL glyph_model k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
        n_tests++;
        if (seg_pat[27:21] !== 7'h63 || hex_ok[3] !== 1'b0 || hex[15:12] !== 4'h0 || dp[3] !== 1'b0 || digit_vld !== 8'h09) begin
            n_fail++; $display("FAIL glyph_digit3 got=%h/%b/%h/%b/%h exp=63/0/0/0/09", seg_pat[27:21], hex_ok[3], hex[15:12], dp[3], digit_vld);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] vld0;
        vld0 = digit_vld;
        for (int k = 0; k < 18; k++) begin
            cycle(1'b0, 8'hFD, ((k / 3) % 2 == 1) ? 8'hF9 : 8'hA4);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs, exp_v); end
            n_tests++;
            if (digit_vld !== vld0 || an_err !== 1'b0) begin
                n_fail++; $display("FAIL bounce_nocap k=%0d got=%h/%b exp=%h/0", k, digit_vld, an_err, vld0);
            end
        end
    endtask

    task automatic test_frame();
        int         seq [5] = '{0, 1, 2, 3, 0};
        logic [7:0] s;
        int         pulses = 0;
        cycle(1'b1, 8'hFF, 8'hFF);
        for (int k = 0; k < 25; k++) begin
            if (k % 5 == 0) s = 8'($urandom_range(0, 255));
            cycle(1'b0, ~(8'h01 << seq[k / 5]), s);
            pulses += int'(frame_done);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL frame_model k=%0d got=%h exp=%h", k, obs, exp_v); end
            n_tests++;
            if (frame_done !== (k == 23)) begin n_fail++; $display("FAIL frame_pulse k=%0d got=%b exp=%b", k, frame_done, k == 23); end
        end
        n_tests++;
        if (digit_vld !== 8'h0F || pulses != 1) begin
            n_fail++; $display("FAIL frame_end got=%h/%0d exp=0f/1", digit_vld, pulses);
        end
    endtask

    task automatic test_an_err_stale();
        logic [55:0] seg0;
        logic [7:0]  vld0;
        seg0 = seg_pat;
        vld0 = digit_vld;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'hFC, 8'h5A);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL anerr_model k=%0d got=%h exp=%h", k, obs, exp_v); end
            n_tests++;
            if (an_err !== (k == NS - 1) || seg_pat !== seg0 || digit_vld !== vld0) begin
                n_fail++; $display("FAIL anerr_pulse k=%0d got=%b/%h exp=%b/%h", k, an_err, digit_vld, k == NS - 1, vld0);
            end
        end
        for (int k = 0; k < TMAX; k++) begin
            cycle(1'b0, 8'hFF, 8'hFF);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL stale_model k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
        n_tests++;
        if (stale !== 1'b1 || digit_vld !== 8'h00 || seg_pat !== seg0) begin
            n_fail++; $display("FAIL stale_level got=%b/%h/%h exp=1/00/%h", stale, digit_vld, seg_pat, seg0);
        end
        for (int k = 0; k < NS; k++) cycle(1'b0, 8'hDF, 8'hC0);
        n_tests++;
        if (stale !== 1'b0 || digit_vld !== 8'h20 || obs !== exp_v) begin
            n_fail++; $display("FAIL stale_recover got=%b/%h exp=0/20", stale, digit_vld);
        end
    endtask

    task automatic test_sat_capture();
        cycle(1'b1, 8'hFF, 8'hFF);
        for (int k = 1; k <= TMAX; k++) begin
            if (k <= TMAX - NS) cycle(1'b0, 8'hFF, 8'hFF);
            else cycle(1'b0, 8'hBF, 8'h92);
            n_tests++;
            if (obs !== exp_v || stale !== 1'b0) begin
                n_fail++; $display("FAIL sat_model k=%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
        n_tests++;
        if (digit_vld !== 8'h40 || stale !== 1'b0) begin
            n_fail++; $display("FAIL sat_capture_wins got=%h/%b exp=40/0", digit_vld, stale);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 8'hEF, 8'hA4);
        cycle(1'b0, 8'hEF, 8'hA4);
        cycle(1'b1, 8'hEF, 8'hA4);
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL midreset_state got=%h exp=0", obs); end
        for (int k = 1; k <= NS; k++) begin
            cycle(1'b0, 8'hEF, 8'hA4);
            n_tests++;
            if (obs !== exp_v || digit_vld !== ((k == NS) ? 8'h10 : 8'h00)) begin
                n_fail++; $display("FAIL midreset_recapture k=%0d got=%h exp=%h", k, digit_vld, (k == NS) ? 8'h10 : 8'h00);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, s;
        int         len, pick;
        for (int b = 0; b < 150; b++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) a = 8'hFF;
            else if (pick == 1) a = 8'($urandom_range(0, 255));
            else a = ~(8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) s = {1'($urandom_range(0, 1)), ~glyph[$urandom_range(0, 15)]};
            else s = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                cycle(($urandom_range(0, 99) == 0), a, s);
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL random_model b=%0d k=%0d got=%h exp=%h", b, k, obs, exp_v); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; an = 8'hFF; sseg = 8'hFF;
        test_reset();
        test_single_capture();
        test_unknown_glyph();
        test_bounce();
        test_frame();
        test_an_err_stale();
        test_sat_capture();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
